univ_ff_reg: RTL

Parametrised WIDTH-bit register that applies JK, D, T or SR flip-flop semantics to every bit, with the mode selected at run time. It succeeds the single-bit JK cell and the D-from-JK conversion, and replaces hand-built converter chains wherever a design needs a bank of flip-flops. It also adds an update enable, synchronous reset, a change indicator, a saturating change counter and a sticky illegal-SR flag.

---
 rtl/univ_ff_reg_pkg.sv | 8 +
 rtl/univ_ff_bit.sv | 21 ++
 rtl/univ_ff_reg.sv | 59 +++++
 3 files changed

// File: rtl/univ_ff_reg_pkg.sv
// univ_ff_reg_pkg: shared mode encoding for the universal flip-flop register
package univ_ff_reg_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_JK = 2'b00;
  localparam mode_t MODE_D  = 2'b01;
  localparam mode_t MODE_T  = 2'b10;
  localparam mode_t MODE_SR = 2'b11;
endpackage

// File: rtl/univ_ff_bit.sv
// univ_ff_bit: combinational next-state for one JK/D/T/SR flip-flop bit
module univ_ff_bit
  import univ_ff_reg_pkg::*;
(
  input  mode_t mode_i,
  input  logic  a_i,
  input  logic  b_i,
  input  logic  q_i,
  output logic  q_next_o,
  output logic  illegal_o
);
  // JK and SR share hold/reset/set; they differ only on a=b=1 (toggle vs hold+flag)
  always_comb begin
    illegal_o = (mode_i == MODE_SR) & a_i & b_i;
    q_next_o  = (mode_i == MODE_D) ? a_i :
                (mode_i == MODE_T) ? q_i ^ a_i :
                (a_i & b_i)        ? ((mode_i == MODE_JK) ? ~q_i : q_i) :
                a_i                ? 1'b1 :
                b_i                ? 1'b0 : q_i;
  end
endmodule

// File: rtl/univ_ff_reg.sv
// univ_ff_reg: WIDTH-bit run-time selectable JK/D/T/SR register with change tracking
module univ_ff_reg
  import univ_ff_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             changed,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             sr_err
);
  logic [WIDTH-1:0] q_q, q_d, q_nx, ill;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             changed_q, changed_d, sr_err_q, sr_err_d;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    univ_ff_bit u_bit (
      .mode_i   (mode),
      .a_i      (a[i]),
      .b_i      (b[i]),
      .q_i      (q_q[i]),
      .q_next_o (q_nx[i]),
      .illegal_o(ill[i])
    );
  end
  // next state: disabled edges freeze everything except changed, which drops
  always_comb begin
    q_d       = en ? q_nx : q_q;
    changed_d = en & (q_d != q_q);
    cnt_d     = (changed_d && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
    sr_err_d  = sr_err_q | (en & |ill);
  end
  // state register with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= '0;
      cnt_q     <= '0;
      changed_q <= 1'b0;
      sr_err_q  <= 1'b0;
    end else begin
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
      sr_err_q  <= sr_err_d;
    end
  end
  assign q       = q_q;
  assign qn      = ~q_q;
  assign changed = changed_q;
  assign chg_cnt = cnt_q;
  assign sr_err  = sr_err_q;
endmodule
